// File: rtl/pu_or1k_pfpu64_prenorm.sv
// Add/sub operand unpack and classify: two adv_i-gated stages, decode to exp10/fract24, NaN/inf flags, |a| vs |b| compare.
// Optional PFPU64_PRENORM_FTZ_EN flushes denormal operands to signed zero before decode and compare.
module pu_or1k_pfpu64_prenorm (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        adv_i,
  input  logic        start_i,
  input  logic        is_sub_i,
  input  logic [31:0] opa_i,
  input  logic [31:0] opb_i,
  output logic        add_start_o,
  output logic        add_is_sub_o,
  output logic        signa_o,
  output logic        signb_o,
  output logic [9:0]  exp10a_o,
  output logic [9:0]  exp10b_o,
  output logic [23:0] fract24a_o,
  output logic [23:0] fract24b_o,
  output logic        infa_o,
  output logic        infb_o,
  output logic        snan_o,
  output logic        qnan_o,
  output logic        anan_sign_o,
  output logic        addsub_agtb_o,
  output logic        addsub_aeqb_o
);

  logic        s1_ready;
  logic        s1_is_sub;
  logic        s1_signa, s1_signb;
  logic [7:0]  s1_expa, s1_expb;
  logic [22:0] s1_manta, s1_mantb;
  logic        s1_expmaxa, s1_expmaxb;
  logic        s1_expzeroa, s1_expzerob;
  logic        s1_mantzeroa, s1_mantzerob;

  // Ready chain: flush wins over adv and clears even while the pipe is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_ready    <= 1'b0;
      add_start_o <= 1'b0;
    end else if (flush_i) begin
      s1_ready    <= 1'b0;
      add_start_o <= 1'b0;
    end else if (adv_i) begin
      s1_ready    <= start_i;
      add_start_o <= s1_ready;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_is_sub    <= 1'b0;
      s1_signa     <= 1'b0;
      s1_signb     <= 1'b0;
      s1_expa      <= 8'd0;
      s1_expb      <= 8'd0;
      s1_manta     <= 23'd0;
      s1_mantb     <= 23'd0;
      s1_expmaxa   <= 1'b0;
      s1_expmaxb   <= 1'b0;
      s1_expzeroa  <= 1'b0;
      s1_expzerob  <= 1'b0;
      s1_mantzeroa <= 1'b0;
      s1_mantzerob <= 1'b0;
    end else if (adv_i) begin
      s1_is_sub    <= is_sub_i;
      s1_signa     <= opa_i[31];
      s1_signb     <= opb_i[31];
      s1_expa      <= opa_i[30:23];
      s1_expb      <= opb_i[30:23];
      s1_manta     <= opa_i[22:0];
      s1_mantb     <= opb_i[22:0];
      s1_expmaxa   <= (opa_i[30:23] == 8'hFF);
      s1_expmaxb   <= (opb_i[30:23] == 8'hFF);
      s1_expzeroa  <= (opa_i[30:23] == 8'h00);
      s1_expzerob  <= (opb_i[30:23] == 8'h00);
      s1_mantzeroa <= (opa_i[22:0] == 23'd0);
      s1_mantzerob <= (opb_i[22:0] == 23'd0);
    end
  end

  logic [22:0] manta_eff, mantb_eff;
`ifdef PFPU64_PRENORM_FTZ_EN
  // A denormal already decodes to exp10 = 1; dropping its mantissa leaves a signed zero.
  assign manta_eff = (s1_expzeroa & ~s1_mantzeroa) ? 23'd0 : s1_manta;
  assign mantb_eff = (s1_expzerob & ~s1_mantzerob) ? 23'd0 : s1_mantb;
`else
  assign manta_eff = s1_manta;
  assign mantb_eff = s1_mantb;
`endif

  logic [9:0]  exp10a, exp10b;
  logic [23:0] fract24a, fract24b;
  logic        nana, nanb, snana, snanb, agtb, aeqb;

  assign exp10a   = s1_expzeroa ? 10'd1 : {2'b00, s1_expa};
  assign exp10b   = s1_expzerob ? 10'd1 : {2'b00, s1_expb};
  assign fract24a = {~s1_expzeroa, manta_eff};
  assign fract24b = {~s1_expzerob, mantb_eff};
  assign nana     = s1_expmaxa & ~s1_mantzeroa;
  assign nanb     = s1_expmaxb & ~s1_mantzerob;
  assign snana    = nana & ~s1_manta[22];
  assign snanb    = nanb & ~s1_mantb[22];
  assign agtb     = (exp10a > exp10b) | ((exp10a == exp10b) & (fract24a > fract24b));
  assign aeqb     = (exp10a == exp10b) & (fract24a == fract24b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_is_sub_o  <= 1'b0;
      signa_o       <= 1'b0;
      signb_o       <= 1'b0;
      exp10a_o      <= 10'd0;
      exp10b_o      <= 10'd0;
      fract24a_o    <= 24'd0;
      fract24b_o    <= 24'd0;
      infa_o        <= 1'b0;
      infb_o        <= 1'b0;
      snan_o        <= 1'b0;
      qnan_o        <= 1'b0;
      anan_sign_o   <= 1'b0;
      addsub_agtb_o <= 1'b0;
      addsub_aeqb_o <= 1'b0;
    end else if (adv_i) begin
      add_is_sub_o  <= s1_is_sub;
      signa_o       <= s1_signa;
      signb_o       <= s1_signb;
      exp10a_o      <= exp10a;
      exp10b_o      <= exp10b;
      fract24a_o    <= fract24a;
      fract24b_o    <= fract24b;
      infa_o        <= s1_expmaxa & s1_mantzeroa;
      infb_o        <= s1_expmaxb & s1_mantzerob;
      snan_o        <= snana | snanb;
      qnan_o        <= nana | nanb;
      anan_sign_o   <= nana ? s1_signa : s1_signb;
      addsub_agtb_o <= agtb;
      addsub_aeqb_o <= aeqb;
    end
  end

endmodule

// File: tb/tb_pu_or1k_pfpu64_prenorm.sv
// Directed bench for pu_or1k_pfpu64_prenorm: hand-computed decode, classify, compare and pipe-control vectors.
module tb_pu_or1k_pfpu64_prenorm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic        adv_i = 1'b0;
  logic        start_i = 1'b0;
  logic        is_sub_i = 1'b0;
  logic [31:0] opa_i = 32'd0;
  logic [31:0] opb_i = 32'd0;
  logic        add_start_o, add_is_sub_o, signa_o, signb_o;
  logic [9:0]  exp10a_o, exp10b_o;
  logic [23:0] fract24a_o, fract24b_o;
  logic        infa_o, infb_o, snan_o, qnan_o, anan_sign_o;
  logic        addsub_agtb_o, addsub_aeqb_o;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pu_or1k_pfpu64_prenorm dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .adv_i(adv_i),
    .start_i(start_i), .is_sub_i(is_sub_i), .opa_i(opa_i), .opb_i(opb_i),
    .add_start_o(add_start_o), .add_is_sub_o(add_is_sub_o),
    .signa_o(signa_o), .signb_o(signb_o),
    .exp10a_o(exp10a_o), .exp10b_o(exp10b_o),
    .fract24a_o(fract24a_o), .fract24b_o(fract24b_o),
    .infa_o(infa_o), .infb_o(infb_o),
    .snan_o(snan_o), .qnan_o(qnan_o), .anan_sign_o(anan_sign_o),
    .addsub_agtb_o(addsub_agtb_o), .addsub_aeqb_o(addsub_aeqb_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub);
    opa_i = a; opb_i = b; is_sub_i = sub; start_i = 1'b1; adv_i = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    #12;
    chk("rst_start", add_start_o, 0);
    chk("rst_exp10a", exp10a_o, 0);
    chk("rst_fract24b", fract24b_o, 0);
    chk("rst_flags", {infa_o, qnan_o, snan_o, addsub_aeqb_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // 1.0 vs 2.0
    issue(32'h3F800000, 32'h40000000, 1'b0);
    chk("add_start", add_start_o, 1);
    chk("exp10a_1p0", exp10a_o, 127);
    chk("fract24a_1p0", fract24a_o, 24'h800000);
    chk("exp10b_2p0", exp10b_o, 128);
    chk("fract24b_2p0", fract24b_o, 24'h800000);
    chk("agtb_aeqb_1v2", {addsub_agtb_o, addsub_aeqb_o}, 2'b00);
    chk("is_sub_0", add_is_sub_o, 0);

    // pi vs -pi, subtract
    issue(32'h40490FDB, 32'hC0490FDB, 1'b1);
    chk("agtb_aeqb_pi", {addsub_agtb_o, addsub_aeqb_o}, 2'b01);
    chk("signs_pi", {signa_o, signb_o}, 2'b01);
    chk("is_sub_1", add_is_sub_o, 1);

    // same exponent, larger fraction; sign ignored on a smaller-magnitude pair
    issue(32'h3FC00000, 32'hBF800000, 1'b0);
    chk("agtb_frac", {addsub_agtb_o, addsub_aeqb_o}, 2'b10);
    issue(32'h3F800000, 32'hC0000000, 1'b0);
    chk("altb_signed", {addsub_agtb_o, addsub_aeqb_o}, 2'b00);

    // sNaN vs qNaN, then swapped
    issue(32'h7F800001, 32'hFFC00000, 1'b0);
    chk("nan_flags", {snan_o, qnan_o, anan_sign_o}, 3'b110);
    issue(32'hFFC00000, 32'h7F800001, 1'b0);
    chk("nan_flags_swap", {snan_o, qnan_o, anan_sign_o}, 3'b111);
    issue(32'h7FC00000, 32'h3F800000, 1'b0);
    chk("qnan_only", {snan_o, qnan_o, anan_sign_o}, 3'b010);

    // +inf vs -inf
    issue(32'h7F800000, 32'hFF800000, 1'b0);
    chk("inf_flags", {infa_o, infb_o, qnan_o}, 3'b110);
    chk("inf_exp", {exp10a_o, exp10b_o}, {10'd255, 10'd255});
    chk("inf_fract_a", fract24a_o, 24'h800000);
    chk("inf_fract_b", fract24b_o, 24'h800000);
    chk("inf_aeqb", {addsub_agtb_o, addsub_aeqb_o}, 2'b01);

    // smallest denormal vs zero
    issue(32'h00000001, 32'h00000000, 1'b0);
    chk("den_exp", {exp10a_o, exp10b_o}, {10'd1, 10'd1});
    chk("den_fract_b", fract24b_o, 0);
`ifdef PFPU64_PRENORM_FTZ_EN
    chk("den_fract_a", fract24a_o, 0);
    chk("den_cmp", {addsub_agtb_o, addsub_aeqb_o}, 2'b01);
`else
    chk("den_fract_a", fract24a_o, 1);
    chk("den_cmp", {addsub_agtb_o, addsub_aeqb_o}, 2'b10);
`endif

    // stall: 3.0 sits in stage 1 while adv_i is low
    opa_i = 32'h40400000; opb_i = 32'h3F800000; start_i = 1'b1; adv_i = 1'b1;
    tick();
    adv_i = 1'b0; start_i = 1'b0; opa_i = 32'h7F800000;
    tick(); tick(); tick();
    chk("stall_start", add_start_o, 1);
    chk("stall_exp10a", exp10a_o, 1);
    adv_i = 1'b1;
    tick();
    chk("resume_start", add_start_o, 1);
    chk("resume_exp10a", exp10a_o, 128);
    chk("resume_fract24a", fract24a_o, 24'hC00000);
    tick();
    chk("drain_start", add_start_o, 0);

    // flush with an op in stage 1
    opa_i = 32'h3F800000; opb_i = 32'h3F800000; start_i = 1'b1;
    tick();
    flush_i = 1'b1; start_i = 1'b0;
    tick();
    chk("flush_start0", add_start_o, 0);
    flush_i = 1'b0;
    tick();
    chk("flush_start1", add_start_o, 0);

    // reset mid-flight
    issue(32'h3F800000, 32'h40000000, 1'b0);
    chk("pre_rst_start", add_start_o, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_start", add_start_o, 0);
    chk("rst_mid_exp10a", exp10a_o, 0);
    chk("rst_mid_fract24a", fract24a_o, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst_edge1", add_start_o, 0);
    tick();
    chk("post_rst_edge2", add_start_o, 1);
    chk("post_rst_exp10b", exp10b_o, 128);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
